// File: rtl/fu_issue_port_if.sv
// Controller <-> functional unit interface: instruction presentation towards the FU,
// unstallable result return from the FU.
interface fu_if #(
    parameter int INST_ID_BITS = 6,
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3
) ();
    logic                    inst_valid;
    logic [INST_ID_BITS-1:0] inst_id;
    logic [31:0]             inst;
    logic [63:0]             op      [MAX_OPERANDS];
    logic [PRN_BITS-1:0]     out_prn [MAX_OPERANDS];
    logic [63:0]             pc;

    logic                    fu_out_valid;
    logic [INST_ID_BITS-1:0] fu_out_inst_id;
    logic [PRN_BITS-1:0]     fu_out_prn        [MAX_OPERANDS];
    logic [63:0]             fu_out_data       [MAX_OPERANDS];
    logic                    fu_out_data_valid [MAX_OPERANDS];

    modport ctrl (
        output inst_valid, inst_id, inst, op, out_prn, pc,
        input  fu_out_valid, fu_out_inst_id, fu_out_prn, fu_out_data, fu_out_data_valid
    );

    modport fu (
        input  inst_valid, inst_id, inst, op, out_prn, pc,
        output fu_out_valid, fu_out_inst_id, fu_out_prn, fu_out_data, fu_out_data_valid
    );
endinterface

// File: rtl/fu_issue_port.sv
// Issue-side driver for one functional unit: credit-gated issue, one-cycle inst_valid
// pulse, and a show-ahead result FIFO draining to the writeback arbiter.
module fu_issue_port #(
    parameter int INST_ID_BITS = 6,
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3,
    parameter int RES_DEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    iss_valid,
    output logic                    iss_ready,
    input  logic [INST_ID_BITS-1:0] iss_inst_id,
    input  logic [31:0]             iss_inst,
    input  logic [63:0]             iss_op      [MAX_OPERANDS],
    input  logic [PRN_BITS-1:0]     iss_out_prn [MAX_OPERANDS],
    input  logic [63:0]             iss_pc,
    fu_if.ctrl                      fu,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic [INST_ID_BITS-1:0] wb_inst_id,
    output logic [PRN_BITS-1:0]     wb_prn        [MAX_OPERANDS],
    output logic [63:0]             wb_data       [MAX_OPERANDS],
    output logic                    wb_data_valid [MAX_OPERANDS],
    output logic                    ovf_err
);
    localparam int PTR_W = $clog2(RES_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RES_DEPTH);

    logic [CNT_W-1:0]        reserved_reg, reserved_next;
    logic [CNT_W-1:0]        count_reg, count_next;
    logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
    logic                    ovf_err_reg;
    logic                    inst_valid_reg;
    logic [INST_ID_BITS-1:0] inst_id_reg;
    logic [31:0]             inst_reg;
    logic [63:0]             pc_reg;
    logic [INST_ID_BITS-1:0] id_mem [RES_DEPTH];

    logic iss_fire, wb_fire, fifo_full, push_ok, ovf_evt;

    // Credit check uses only the registered count: a pop frees a slot one cycle later.
    assign iss_ready = rst && (reserved_reg < DEPTH_CNT);
    assign iss_fire  = iss_valid && iss_ready;
    assign wb_valid  = (count_reg != '0);
    assign wb_fire   = wb_valid && wb_ready;
    assign fifo_full = (count_reg == DEPTH_CNT);
    assign push_ok   = fu.fu_out_valid && (!fifo_full || wb_fire);
    assign ovf_evt   = fu.fu_out_valid && fifo_full && !wb_fire;

    always_comb begin
        reserved_next = reserved_reg;
        case ({iss_fire, wb_fire})
            2'b10:   reserved_next = reserved_reg + 1'b1;
            2'b01:   reserved_next = reserved_reg - 1'b1;
            default: reserved_next = reserved_reg;
        endcase
    end

    always_comb begin
        count_next = count_reg;
        case ({push_ok, wb_fire})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reserved_reg   <= '0;
            count_reg      <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            ovf_err_reg    <= 1'b0;
            inst_valid_reg <= 1'b0;
            inst_id_reg    <= '0;
            inst_reg       <= '0;
            pc_reg         <= '0;
        end else begin
            reserved_reg   <= reserved_next;
            count_reg      <= count_next;
            inst_valid_reg <= iss_fire;
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (wb_fire) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (ovf_evt) ovf_err_reg <= 1'b1;
            if (iss_fire) begin
                inst_id_reg <= iss_inst_id;
                inst_reg    <= iss_inst;
                pc_reg      <= iss_pc;
            end
        end
    end

    // FIFO payload needs no reset: count_reg alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push_ok) id_mem[wr_ptr_reg] <= fu.fu_out_inst_id;
    end

    assign wb_inst_id    = id_mem[rd_ptr_reg];
    assign ovf_err       = ovf_err_reg;
    assign fu.inst_valid = inst_valid_reg;
    assign fu.inst_id    = inst_id_reg;
    assign fu.inst       = inst_reg;
    assign fu.pc         = pc_reg;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_OPERANDS; gi++) begin : g_slot
            logic [63:0]         op_reg;
            logic [PRN_BITS-1:0] out_prn_reg;
            logic [PRN_BITS-1:0] prn_mem  [RES_DEPTH];
            logic [63:0]         data_mem [RES_DEPTH];
            logic                dv_mem   [RES_DEPTH];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    op_reg      <= '0;
                    out_prn_reg <= '0;
                end else if (iss_fire) begin
                    op_reg      <= iss_op[gi];
                    out_prn_reg <= iss_out_prn[gi];
                end
            end

            always_ff @(posedge clk) begin
                if (push_ok) begin
                    prn_mem[wr_ptr_reg]  <= fu.fu_out_prn[gi];
                    data_mem[wr_ptr_reg] <= fu.fu_out_data[gi];
                    dv_mem[wr_ptr_reg]   <= fu.fu_out_data_valid[gi];
                end
            end

            assign fu.op[gi]         = op_reg;
            assign fu.out_prn[gi]    = out_prn_reg;
            assign wb_prn[gi]        = prn_mem[rd_ptr_reg];
            assign wb_data[gi]       = data_mem[rd_ptr_reg];
            assign wb_data_valid[gi] = dv_mem[rd_ptr_reg];
        end
    endgenerate
endmodule

// File: tb/tb_fu_issue_port.sv
// Directed bench for fu_issue_port: reset, single op, credits, wrap with backpressure,
// overflow and mid-stream reset.
module tb_fu_issue_port;
    localparam int IDB = 6;
    localparam int PB  = 6;
    localparam int NOP = 3;
    localparam int DEP = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           iss_valid, iss_ready;
    logic [IDB-1:0] iss_inst_id;
    logic [31:0]    iss_inst;
    logic [63:0]    iss_op      [NOP];
    logic [PB-1:0]  iss_out_prn [NOP];
    logic [63:0]    iss_pc;
    logic           wb_valid, wb_ready;
    logic [IDB-1:0] wb_inst_id;
    logic [PB-1:0]  wb_prn        [NOP];
    logic [63:0]    wb_data       [NOP];
    logic           wb_data_valid [NOP];
    logic           ovf_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fu_if #(.INST_ID_BITS(IDB), .PRN_BITS(PB), .MAX_OPERANDS(NOP)) fu_bus ();

    fu_issue_port #(.INST_ID_BITS(IDB), .PRN_BITS(PB), .MAX_OPERANDS(NOP), .RES_DEPTH(DEP)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_inst_id(iss_inst_id),
        .iss_inst(iss_inst), .iss_op(iss_op), .iss_out_prn(iss_out_prn), .iss_pc(iss_pc),
        .fu(fu_bus),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_inst_id(wb_inst_id),
        .wb_prn(wb_prn), .wb_data(wb_data), .wb_data_valid(wb_data_valid),
        .ovf_err(ovf_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // FU result pattern: prn = id+slot, data = id*16+slot, slot 2 marked invalid
    task automatic fu_ret(input logic v, input int id);
        fu_bus.fu_out_valid   = v;
        fu_bus.fu_out_inst_id = IDB'(id);
        for (int i = 0; i < NOP; i++) begin
            fu_bus.fu_out_prn[i]        = PB'(id + i);
            fu_bus.fu_out_data[i]       = 64'(id * 16 + i);
            fu_bus.fu_out_data_valid[i] = (i != 2);
        end
    endtask

    task automatic issue(input logic v, input int id);
        iss_valid   = v;
        iss_inst_id = IDB'(id);
        iss_inst    = 32'(id + 32'h100);
        iss_pc      = 64'(id * 4);
        for (int i = 0; i < NOP; i++) begin
            iss_op[i]      = 64'(id + i);
            iss_out_prn[i] = PB'(id + i);
        end
    endtask

    initial begin
        int issued;
        int popped;
        int due_q[$];
        int id_q[$];
        int exp_ids[4];

        issue(1'b0, 0);
        fu_ret(1'b0, 0);
        wb_ready = 1'b0;

        // Reset held with a pending issue request
        issue(1'b1, 1);
        cyc(); cyc();
        check("rst_iss_ready", iss_ready, 0);
        check("rst_inst_valid", fu_bus.inst_valid, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_ovf", ovf_err, 0);
        check("rst_fu_op0", fu_bus.op[0], 0);
        issue(1'b0, 0);
        rst = 1'b1;
        #1;
        check("rel_iss_ready", iss_ready, 1);
        cyc();

        // Single op
        issue(1'b1, 5);
        iss_op[0] = 64'h10;
        #1;
        check("t2_iss_ready", iss_ready, 1);
        check("t2_no_pulse_early", fu_bus.inst_valid, 0);
        cyc();
        issue(1'b0, 33);
        #1;
        check("t2_pulse", fu_bus.inst_valid, 1);
        check("t2_fu_id", fu_bus.inst_id, 5);
        check("t2_fu_op0", fu_bus.op[0], 64'h10);
        check("t2_fu_pc", fu_bus.pc, 64'd20);
        cyc();
        check("t2_pulse_end", fu_bus.inst_valid, 0);
        check("t2_op_hold", fu_bus.op[0], 64'h10);
        fu_ret(1'b1, 5);
        fu_bus.fu_out_prn[0]  = 6'd7;
        fu_bus.fu_out_data[0] = 64'h20;
        #1;
        check("t2_wb_not_yet", wb_valid, 0);
        cyc();
        fu_ret(1'b0, 0);
        #1;
        check("t2_wb_valid", wb_valid, 1);
        check("t2_wb_id", wb_inst_id, 5);
        check("t2_wb_prn0", wb_prn[0], 7);
        check("t2_wb_data0", wb_data[0], 64'h20);
        wb_ready = 1'b1;
        $display("t2 wb pop id=%0d", wb_inst_id);
        cyc();
        wb_ready = 1'b0;
        #1;
        check("t2_wb_empty", wb_valid, 0);

        // Credit full: four issues with a silent FU
        for (int k = 0; k < 4; k++) begin
            issue(1'b1, k);
            #1;
            check("t3_accept_ready", iss_ready, 1);
            cyc();
        end
        issue(1'b1, 9);
        #1;
        check("t3_full_blocked", iss_ready, 0);
        check("t3_last_pulse", fu_bus.inst_id, 3);
        cyc();
        check("t3_still_blocked", iss_ready, 0);
        issue(1'b0, 0);
        for (int k = 0; k < 4; k++) begin
            fu_ret(1'b1, k);
            cyc();
        end
        fu_ret(1'b0, 0);
        #1;
        check("t3_fifo_head", wb_inst_id, 0);
        check("t3_no_ovf", ovf_err, 0);
        // reserved=4: pop and issue together -> issue blocked this cycle
        wb_ready = 1'b1;
        issue(1'b1, 40);
        #1;
        check("t4_pop_no_bypass", iss_ready, 0);
        cyc();
        wb_ready = 1'b0;
        #1;
        check("t4_ready_next_cycle", iss_ready, 1);
        check("t4_head_after_pop", wb_inst_id, 1);
        cyc();
        wb_ready = 1'b1;
        #1;
        check("t4_refull_blocked", iss_ready, 0);
        cyc();
        // reserved=3: issue and pop together leave it at 3
        #1;
        check("t4_r3_ready", iss_ready, 1);
        check("t4_r3_head", wb_inst_id, 2);
        cyc();
        wb_ready = 1'b0;
        issue(1'b0, 0);
        #1;
        check("t4_r3_kept", iss_ready, 1);
        check("t4_head3", wb_inst_id, 3);
        issue(1'b1, 41);
        cyc();
        issue(1'b0, 0);
        #1;
        check("t4_r4_blocked", iss_ready, 0);
        rst = 1'b0;
        #1;
        check("t4_rst_wb_valid", wb_valid, 0);
        cyc();
        rst = 1'b1;
        #1;
        check("t4_rel_ready", iss_ready, 1);
        cyc();

        // Wrap with backpressure: FU returns each id two cycles after accept
        issued = 0;
        popped = 0;
        for (int n = 0; n < 200 && popped < 10; n++) begin
            issue(issued < 10, issued);
            if (due_q.size() > 0 && due_q[0] == n) begin
                fu_ret(1'b1, id_q[0]);
                void'(due_q.pop_front());
                void'(id_q.pop_front());
            end else begin
                fu_ret(1'b0, 0);
            end
            wb_ready = (n % 2) == 1;
            #1;
            if (iss_valid && iss_ready) begin
                due_q.push_back(n + 2);
                id_q.push_back(issued);
                issued++;
            end
            if (wb_valid && wb_ready) begin
                $display("t5 wb pop id=%0d data0=0x%0h", wb_inst_id, wb_data[0]);
                check("t5_id", wb_inst_id, 64'(popped));
                check("t5_data0", wb_data[0], 64'(popped * 16));
                check("t5_prn1", wb_prn[1], 64'(popped + 1));
                check("t5_dv2", wb_data_valid[2], 0);
                popped++;
            end
            cyc();
        end
        issue(1'b0, 0);
        fu_ret(1'b0, 0);
        wb_ready = 1'b0;
        #1;
        check("t5_all_out", 64'(popped), 10);
        check("t5_no_ovf", ovf_err, 0);
        check("t5_empty", wb_valid, 0);
        cyc();

        // Overflow on a full FIFO
        for (int k = 0; k < 4; k++) begin
            issue(1'b1, k);
            cyc();
        end
        issue(1'b0, 0);
        for (int k = 0; k < 4; k++) begin
            fu_ret(1'b1, 10 + k);
            cyc();
        end
        fu_ret(1'b1, 14);
        #1;
        check("t6_ovf_before", ovf_err, 0);
        cyc();
        fu_ret(1'b0, 0);
        #1;
        check("t6_ovf_set", ovf_err, 1);
        check("t6_head_kept", wb_inst_id, 10);
        cyc();
        check("t6_ovf_sticky", ovf_err, 1);
        // Push while full with a pop is accepted
        fu_ret(1'b1, 15);
        wb_ready = 1'b1;
        #1;
        check("t6_pp_head", wb_inst_id, 10);
        cyc();
        fu_ret(1'b0, 0);
        wb_ready = 1'b0;
        issue(1'b1, 50);
        #1;
        check("t6_credit_back", iss_ready, 1);
        cyc();
        issue(1'b0, 0);
        exp_ids = '{11, 12, 13, 15};
        for (int k = 0; k < 4; k++) begin
            wb_ready = 1'b1;
            #1;
            $display("t6 wb pop id=%0d", wb_inst_id);
            check("t6_drain_valid", wb_valid, 1);
            check("t6_drain_id", wb_inst_id, 64'(exp_ids[k]));
            cyc();
        end
        wb_ready = 1'b0;
        #1;
        check("t6_dropped_gone", wb_valid, 0);
        check("t6_ovf_still", ovf_err, 1);

        // Reset mid-stream
        issue(1'b1, 20);
        fu_ret(1'b1, 20);
        cyc();
        issue(1'b0, 0);
        fu_ret(1'b0, 0);
        #1;
        check("t6_pre_rst_wb", wb_valid, 1);
        rst = 1'b0;
        #1;
        check("t6_rst_wb", wb_valid, 0);
        check("t6_rst_ovf", ovf_err, 0);
        check("t6_rst_ready", iss_ready, 0);
        check("t6_rst_pulse", fu_bus.inst_valid, 0);
        cyc();
        rst = 1'b1;
        #1;
        check("t6_rel_ready", iss_ready, 1);
        check("t6_rel_empty", wb_valid, 0);
        fu_ret(1'b1, 21);
        cyc();
        fu_ret(1'b0, 0);
        #1;
        check("t6_post_rst_capture", wb_valid, 1);
        check("t6_post_rst_id", wb_inst_id, 21);
        check("t6_post_rst_ovf", ovf_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
